vec_add_engine: RTL and testbench

// - Memory-initiator that computes C[i] = A[i] + B[i] for i = 0..LEN-1.
// - Drives the two registered read ports and the one delayed write port of a RAM_1_3-style memory.
// - Streams one element per cycle. Signals completion on valid.
// - Sits in the same tb harness slot as other HLS kernels: memory is preloaded under rst, then rst deasserts to start the run.
//

---
 rtl/vec_add_engine.sv | 66 ++++++
 tb/tb_vec_add_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_add_engine.sv
// vec_add_engine: streams C[i] = A[i] + B[i] over two registered read ports and one delayed write port.
// Define VEC_ADD_SAT_EN to saturate overflowing sums instead of wrapping.
module vec_add_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN = 4,
  parameter int A_BASE = 0,
  parameter int B_BASE = 4,
  parameter int C_BASE = 8
) (
  input  logic clk,
  input  logic rst,
  output logic [ADDR_WIDTH-1:0] raddr_0,
  output logic ren_0,
  input  logic [DATA_WIDTH-1:0] rdata_0,
  output logic [ADDR_WIDTH-1:0] raddr_1,
  output logic ren_1,
  input  logic [DATA_WIDTH-1:0] rdata_1,
  output logic [ADDR_WIDTH-1:0] waddr_0,
  output logic [DATA_WIDTH-1:0] wdata_0,
  output logic wen_0,
  output logic valid
);
  typedef enum logic [1:0] {ISSUE, DRAIN, WAIT, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] sum, wdata_q;
`ifdef VEC_ADD_SAT_EN
  logic [DATA_WIDTH:0] sum_full;
  assign sum_full = {1'b0, rdata_0} + {1'b0, rdata_1};
  assign sum = sum_full[DATA_WIDTH] ? '1 : sum_full[DATA_WIDTH-1:0];
`else
  assign sum = rdata_0 + rdata_1;
`endif
  // read data arrives the cycle after issue, so the sum is formed combinationally in the write cycle
  assign wdata_0 = wen_0 ? sum : wdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ISSUE;
      idx <= '0;
      raddr_0 <= '0;
      raddr_1 <= '0;
      ren_0 <= 1'b0;
      ren_1 <= 1'b0;
      waddr_0 <= '0;
      wen_0 <= 1'b0;
      wdata_q <= '0;
      valid <= 1'b0;
    end else begin
      wdata_q <= wdata_0;
      wen_0 <= ren_0;
      ren_0 <= state == ISSUE;
      ren_1 <= state == ISSUE;
      valid <= state == DONE;
      // idx has already advanced past the element whose data is now returning
      if (ren_0) waddr_0 <= ADDR_WIDTH'(C_BASE) + idx - ADDR_WIDTH'(1);
      if (state == ISSUE) begin
        raddr_0 <= ADDR_WIDTH'(A_BASE) + idx;
        raddr_1 <= ADDR_WIDTH'(B_BASE) + idx;
        idx <= idx + ADDR_WIDTH'(1);
      end
      state <= state == ISSUE ? (idx == ADDR_WIDTH'(LEN - 1) ? DRAIN : ISSUE) :
               state == DRAIN ? WAIT : DONE;
    end
  end
endmodule

// File: tb/tb_vec_add_engine.sv
// tb_vec_add_engine: scoreboarded directed runs of vec_add_engine against a registered-read, delayed-write RAM model.
module tb_vec_add_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic a_rst, b_rst;
  logic [31:0] a_raddr_0, a_raddr_1, a_waddr_0, a_rdata_0, a_rdata_1, a_wdata_0;
  logic a_ren_0, a_ren_1, a_wen_0, a_valid;
  logic [31:0] b_raddr_0, b_raddr_1, b_waddr_0, b_rdata_0, b_rdata_1, b_wdata_0;
  logic b_ren_0, b_ren_1, b_wen_0, b_valid;
  logic [31:0] a_mem [64], a_img [64], b_mem [64], b_img [64];
  logic a_st_en, b_st_en;
  logic [5:0] a_st_a, b_st_a;
  logic [31:0] a_st_d, b_st_d;
  logic [63:0] q_a [$], q_b [$];

  vec_add_engine dut_a (
    .clk(clk), .rst(a_rst),
    .raddr_0(a_raddr_0), .ren_0(a_ren_0), .rdata_0(a_rdata_0),
    .raddr_1(a_raddr_1), .ren_1(a_ren_1), .rdata_1(a_rdata_1),
    .waddr_0(a_waddr_0), .wdata_0(a_wdata_0), .wen_0(a_wen_0), .valid(a_valid)
  );

  vec_add_engine #(.LEN(1), .A_BASE(30), .B_BASE(29), .C_BASE(31)) dut_b (
    .clk(clk), .rst(b_rst),
    .raddr_0(b_raddr_0), .ren_0(b_ren_0), .rdata_0(b_rdata_0),
    .raddr_1(b_raddr_1), .ren_1(b_ren_1), .rdata_1(b_rdata_1),
    .waddr_0(b_waddr_0), .wdata_0(b_wdata_0), .wen_0(b_wen_0), .valid(b_valid)
  );

  // RAM models: image loads while rst is high, writes commit one edge after capture
  always @(posedge clk) begin
    if (a_ren_0) a_rdata_0 <= a_mem[a_raddr_0[5:0]];
    if (a_ren_1) a_rdata_1 <= a_mem[a_raddr_1[5:0]];
    a_st_en <= a_wen_0;
    a_st_a <= a_waddr_0[5:0];
    a_st_d <= a_wdata_0;
    if (a_rst) a_mem <= a_img;
    else if (a_st_en) a_mem[a_st_a] <= a_st_d;
  end

  always @(posedge clk) begin
    if (b_ren_0) b_rdata_0 <= b_mem[b_raddr_0[5:0]];
    if (b_ren_1) b_rdata_1 <= b_mem[b_raddr_1[5:0]];
    b_st_en <= b_wen_0;
    b_st_a <= b_waddr_0[5:0];
    b_st_d <= b_wdata_0;
    if (b_rst) b_mem <= b_img;
    else if (b_st_en) b_mem[b_st_a] <= b_st_d;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_basic();
    q_a.push_back({32'd8, 32'd13});
    q_a.push_back({32'd9, 32'd6});
    q_a.push_back({32'd10, 32'd7});
    q_a.push_back({32'd11, 32'd5});
  endtask

  task automatic check_basic_mem(input string tag);
    chk({tag, "_mem8"}, a_mem[8], 32'd13);
    chk({tag, "_mem9"}, a_mem[9], 32'd6);
    chk({tag, "_mem10"}, a_mem[10], 32'd7);
    chk({tag, "_mem11"}, a_mem[11], 32'd5);
  endtask

  task automatic wait_a_valid(input string tag);
    int k = 0;
    while (!a_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid_timeout"}, 32'(a_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    if (a_wen_0) begin
      if (q_a.size() == 0) chk("a_unexpected_write", a_waddr_0, 32'hFFFFFFFF);
      else begin
        logic [63:0] e;
        e = q_a.pop_front();
        chk("a_waddr", a_waddr_0, e[63:32]);
        chk("a_wdata", a_wdata_0, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (b_wen_0) begin
      if (q_b.size() == 0) chk("b_unexpected_write", b_waddr_0, 32'hFFFFFFFF);
      else begin
        logic [63:0] e;
        e = q_b.pop_front();
        chk("b_waddr", b_waddr_0, e[63:32]);
        chk("b_wdata", b_wdata_0, e[31:0]);
      end
    end
  end

  initial begin
    a_rst = 1'b1;
    b_rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a_img[i] = '0;
      b_img[i] = '0;
    end
    a_img[0] = 6; a_img[1] = 1; a_img[2] = 2; a_img[3] = 3;
    a_img[4] = 7; a_img[5] = 5; a_img[6] = 5; a_img[7] = 2;
    b_img[30] = 9; b_img[29] = 9;
    repeat (3) @(negedge clk);
    chk("rst_ren_0", 32'(a_ren_0), 0);
    chk("rst_wen_0", 32'(a_wen_0), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_wdata_0", a_wdata_0, 0);
    // basic run with per-cycle handshake timing
    push_basic();
    a_rst = 1'b0;
    for (int n = 0; n < 106; n++) begin
      @(negedge clk);
      chk("t_ren_0", 32'(a_ren_0), 32'(n <= 3));
      chk("t_ren_1", 32'(a_ren_1), 32'(n <= 3));
      chk("t_wen_0", 32'(a_wen_0), 32'(n >= 1 && n <= 4));
      chk("t_valid", 32'(a_valid), 32'(n >= 6));
    end
    check_basic_mem("basic");
    chk("basic_a_kept", a_mem[0], 32'd6);
    // overflow
    a_img[0] = 32'hFFFFFFFF;
    a_img[4] = 2;
    a_rst = 1'b1;
    repeat (2) @(negedge clk);
`ifdef VEC_ADD_SAT_EN
    q_a.push_back({32'd8, 32'hFFFFFFFF});
`else
    q_a.push_back({32'd8, 32'd1});
`endif
    q_a.push_back({32'd9, 32'd6});
    q_a.push_back({32'd10, 32'd7});
    q_a.push_back({32'd11, 32'd5});
    a_rst = 1'b0;
    @(negedge clk);
    wait_a_valid("ovf");
`ifdef VEC_ADD_SAT_EN
    chk("ovf_mem8", a_mem[8], 32'hFFFFFFFF);
`else
    chk("ovf_mem8", a_mem[8], 32'd1);
`endif
    // reset mid-run at cycle 2
    a_img[0] = 6;
    a_img[4] = 7;
    a_rst = 1'b1;
    repeat (2) @(negedge clk);
    q_a.push_back({32'd8, 32'd13});
    push_basic();
    a_rst = 1'b0;
    repeat (2) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    chk("mid_ren_0", 32'(a_ren_0), 0);
    chk("mid_ren_1", 32'(a_ren_1), 0);
    chk("mid_raddr_0", a_raddr_0, 0);
    chk("mid_raddr_1", a_raddr_1, 0);
    chk("mid_wen_0", 32'(a_wen_0), 0);
    chk("mid_waddr_0", a_waddr_0, 0);
    chk("mid_wdata_0", a_wdata_0, 0);
    chk("mid_valid", 32'(a_valid), 0);
    a_rst = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      chk("mid_valid_rise", 32'(a_valid), 32'(n == 6));
    end
    check_basic_mem("mid");
    // reset while in DONE
    repeat (3) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    chk("done_rst_valid", 32'(a_valid), 0);
    chk("done_rst_mem8_cleared", a_mem[8], 0);
    push_basic();
    a_rst = 1'b0;
    @(negedge clk);
    wait_a_valid("rerun");
    check_basic_mem("rerun");
    // boundary instance, LEN=1
    q_b.push_back({32'd31, 32'd18});
    b_rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("b_ren_0", 32'(b_ren_0), 32'(n == 0));
      chk("b_wen_0", 32'(b_wen_0), 32'(n == 1));
      chk("b_valid", 32'(b_valid), 32'(n >= 3));
    end
    chk("b_mem31", b_mem[31], 32'd18);
    chk("b_mem30", b_mem[30], 32'd9);
    chk("q_a_left", q_a.size(), 0);
    chk("q_b_left", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
